// File: rtl/tri_pkg.sv
// Shared widths, FSM states and helpers for the triangle vertex feeder.
package tri_pkg;

    localparam int VERT_W   = 6;
    localparam int COORD_W  = 3;
    localparam int PIXCNT_W = 7;

    localparam logic [PIXCNT_W-1:0] PIX_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        SEND1,
        SEND2,
        SEND3,
        WAIT_HI,
        WAIT_LO
    } state_t;

    typedef struct packed {
        logic [VERT_W-1:0] v1;
        logic [VERT_W-1:0] v2;
        logic [VERT_W-1:0] v3;
    } tri_t;

    function automatic logic [PIXCNT_W-1:0] sat_inc(
        input logic [PIXCNT_W-1:0] c,
        input logic                en
    );
        return (en && c != PIX_MAX) ? c + 7'd1 : c;
    endfunction

endpackage

// File: rtl/tri_vertex_feeder_if.sv
// Upstream triangle handshake plus engine-side vertex bus.
interface tri_vertex_feeder_if;
    import tri_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [VERT_W-1:0]  in_v1;
    logic [VERT_W-1:0]  in_v2;
    logic [VERT_W-1:0]  in_v3;
    logic               busy;
    logic               po;
    logic               nt;
    logic [COORD_W-1:0] xi;
    logic [COORD_W-1:0] yi;

    modport master (
        input  in_valid, in_v1, in_v2, in_v3, busy, po,
        output in_ready, nt, xi, yi
    );

    modport slave (
        output in_valid, in_v1, in_v2, in_v3, busy, po,
        input  in_ready, nt, xi, yi
    );

endinterface

// File: rtl/tri_pix_counter.sv
// Saturating point counter; clr wins over inc.
module tri_pix_counter
    import tri_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                inc,
    output logic [PIXCNT_W-1:0] count
);

    logic [PIXCNT_W-1:0] count_d;
    logic [PIXCNT_W-1:0] count_q;

    always_comb begin
        count_d = sat_inc(count_q, inc);
        if (clr) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/tri_vertex_feeder.sv
// Feeds one latched triangle (3 vertices) to a raster engine and tracks completion.
// Optional point counting is enabled by defining TRI_PIXCNT_EN.
module tri_vertex_feeder
    import tri_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 4
)
(
    input  logic                 clk,
    input  logic                 reset,
    tri_vertex_feeder_if.master  bus,
    output logic                 tri_done,
    output logic [PIXCNT_W-1:0]  pix_cnt
);

    localparam logic [7:0] TO_LAST = 8'(BUSY_TIMEOUT - 1);

    state_t             state_q, state_d;
    tri_t               hold_q, hold_d;
    logic [7:0]         wait_q, wait_d;
    logic               nt_q, nt_d;
    logic               rdy_q, rdy_d;
    logic               done_q, done_d;
    logic [COORD_W-1:0] xi_q, xi_d;
    logic [COORD_W-1:0] yi_q, yi_d;
    logic [VERT_W-1:0]  vsel;
    logic               accept;
    logic               busy_fall;
    logic               timeout;

    assign accept    = (state_q == IDLE) && rdy_q && bus.in_valid;
    assign busy_fall = (state_q == WAIT_LO) && !bus.busy;
    // wait_q counts cycles elapsed since SEND3
    assign timeout   = (state_q == WAIT_HI) && !bus.busy && (wait_q >= TO_LAST);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        wait_d  = wait_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SEND1;
                    hold_d.v1 = bus.in_v1;
                    hold_d.v2 = bus.in_v2;
                    hold_d.v3 = bus.in_v3;
                end
            end
            SEND1: state_d = SEND2;
            SEND2: state_d = SEND3;
            SEND3: begin
                state_d = WAIT_HI;
                wait_d  = 8'd1;
            end
            WAIT_HI: begin
                if (bus.busy) begin
                    state_d = WAIT_LO;
                end else if (timeout) begin
                    state_d = IDLE;
                end else if (wait_q != 8'hFF) begin
                    wait_d = wait_q + 8'd1;
                end
            end
            WAIT_LO: begin
                if (!bus.busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vsel = '0;
        unique case (state_d)
            SEND1:   vsel = hold_d.v1;
            SEND2:   vsel = hold_d.v2;
            SEND3:   vsel = hold_d.v3;
            default: vsel = '0;
        endcase
        {xi_d, yi_d} = vsel;
        nt_d   = (state_d == SEND1);
        rdy_d  = (state_d == IDLE) && !bus.busy;
        done_d = busy_fall || timeout;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            wait_q  <= '0;
            nt_q    <= 1'b0;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
            xi_q    <= '0;
            yi_q    <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            wait_q  <= wait_d;
            nt_q    <= nt_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
            xi_q    <= xi_d;
            yi_q    <= yi_d;
        end
    end

    assign bus.in_ready = rdy_q;
    assign bus.nt       = nt_q;
    assign bus.xi       = xi_q;
    assign bus.yi       = yi_q;
    assign tri_done     = done_q;

`ifdef TRI_PIXCNT_EN
    logic [PIXCNT_W-1:0] cnt;
    logic [PIXCNT_W-1:0] pix_q, pix_d;
    logic                cnt_inc;

    assign cnt_inc = bus.po && (state_q != IDLE);

    tri_pix_counter u_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr   (accept),
        .inc   (cnt_inc),
        .count (cnt)
    );

    // a point arriving with the busy fall still belongs to this triangle
    always_comb begin
        pix_d = pix_q;
        if (busy_fall) begin
            pix_d = sat_inc(cnt, bus.po);
        end else if (timeout) begin
            pix_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_q <= '0;
        end else begin
            pix_q <= pix_d;
        end
    end

    assign pix_cnt = pix_q;
`else
    logic unused_po;
    assign unused_po = bus.po;
    assign pix_cnt   = '0;
`endif

endmodule

// File: tb/tb_tri_vertex_feeder.sv
// Directed bench for tri_vertex_feeder: cycle-level reference model
// plus hand-computed spot checks of the vertex stream and counts.
module tb_tri_vertex_feeder;
    import tri_pkg::*;

    localparam int TO = 4;
`ifdef TRI_PIXCNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tri_done;
    logic [6:0] pix_cnt;
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         cmp_en = 1'b0;

    tri_vertex_feeder_if bus ();

    tri_vertex_feeder #(.BUSY_TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .tri_done (tri_done),
        .pix_cnt  (pix_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks position within a triangle as a cycle offset
    bit         m_act = 1'b0;
    bit         m_bseen = 1'b0;
    int         m_k = 0;
    int         m_cnt = 0;
    logic [5:0] m_v [3];
    bit         e_nt = 1'b0;
    bit         e_rdy = 1'b0;
    bit         e_done = 1'b0;
    logic [2:0] e_xi = '0;
    logic [2:0] e_yi = '0;
    int         e_pix = 0;

    task automatic m_finish(input int pix);
        m_act  = 1'b0;
        e_done = 1'b1;
        e_pix  = CNT_ON ? ((pix > 127) ? 127 : pix) : 0;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_act = 1'b0; m_k = 0; m_cnt = 0; m_bseen = 1'b0;
            e_nt = 1'b0; e_rdy = 1'b0; e_done = 1'b0;
            e_xi = '0; e_yi = '0; e_pix = 0;
        end else begin
            e_done = 1'b0;
            if (!m_act) begin
                if (bus.in_valid && e_rdy) begin
                    m_act = 1'b1; m_k = 0; m_cnt = 0; m_bseen = 1'b0;
                    m_v[0] = bus.in_v1; m_v[1] = bus.in_v2; m_v[2] = bus.in_v3;
                end
            end else begin
                if (bus.po) m_cnt++;
                if (m_k < 3) m_k++;
                else if (m_bseen) begin
                    if (!bus.busy) m_finish(m_cnt);
                    else m_k++;
                end else if (bus.busy) begin
                    m_bseen = 1'b1; m_k++;
                end else if (m_k + 1 - 2 >= TO) m_finish(0);
                else m_k++;
            end
            e_nt = m_act && (m_k == 0);
            if (m_act && m_k < 3) {e_xi, e_yi} = m_v[m_k];
            else {e_xi, e_yi} = 6'd0;
            e_rdy = !m_act && !bus.busy;
        end
    end

    always @(posedge clk) begin
        #1;
        if (reset && cmp_en) begin
            n_cmp++;
            if ({bus.nt, bus.xi, bus.yi, bus.in_ready, tri_done, pix_cnt} !==
                {e_nt, e_xi, e_yi, e_rdy, e_done, 7'(e_pix)}) begin
                n_bad++;
                $display("FAIL model t=%0t got nt=%b xi=%0d yi=%0d rdy=%b done=%b pix=%0d, expected nt=%b xi=%0d yi=%0d rdy=%b done=%b pix=%0d",
                         $time, bus.nt, bus.xi, bus.yi, bus.in_ready, tri_done, pix_cnt,
                         e_nt, e_xi, e_yi, e_rdy, e_done, e_pix);
            end
        end
    end

    // Offer a triangle at a negedge; returns at the negedge of its SEND1 cycle
    task automatic send(input logic [5:0] a, input logic [5:0] b,
                        input logic [5:0] c, input bit keep);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_v1 = a; bus.in_v2 = b; bus.in_v3 = c;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept", int'(bus.in_ready), 1);
        @(negedge clk);
        if (!keep) bus.in_valid = 1'b0;
    endtask

    // Called at SEND3 negedge: busy for bl cycles, last np cycles (incl. fall) carry po.
    // Returns at the negedge of the expected tri_done cycle.
    task automatic engine(input int bl, input int np);
        for (int i = 0; i <= bl; i++) begin
            @(negedge clk);
            bus.busy = (i < bl);
            bus.po   = (i >= bl + 1 - np);
        end
        @(negedge clk);
        bus.busy = 1'b0;
        bus.po   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_v1 = '0; bus.in_v2 = '0; bus.in_v3 = '0;
        bus.busy = 1'b0; bus.po = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_nt", int'(bus.nt), 0);
        chk("rst_xy", int'({bus.xi, bus.yi}), 0);
        chk("rst_rdy", int'(bus.in_ready), 0);
        chk("rst_done", int'(tri_done), 0);
        chk("rst_pix", int'(pix_cnt), 0);
        reset = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", int'(bus.in_ready), 1);

        // basic triangle, 10 busy cycles, 8 points (last on busy fall)
        send(6'o00, 6'o07, 6'o77, 1'b0);
        chk("t1_nt_s1", int'(bus.nt), 1);
        chk("t1_xy_s1", int'({bus.xi, bus.yi}), 6'o00);
        @(negedge clk);
        chk("t1_nt_s2", int'(bus.nt), 0);
        chk("t1_xy_s2", int'({bus.xi, bus.yi}), 6'o07);
        @(negedge clk);
        chk("t1_nt_s3", int'(bus.nt), 0);
        chk("t1_xy_s3", int'({bus.xi, bus.yi}), 6'o77);
        engine(10, 8);
        chk("t1_done", int'(tri_done), 1);
        chk("t1_pix", int'(pix_cnt), CNT_ON ? 8 : 0);
        @(negedge clk);
        chk("t1_done_1cyc", int'(tri_done), 0);
        chk("t1_pix_hold", int'(pix_cnt), CNT_ON ? 8 : 0);
        chk("t1_xy_idle", int'({bus.xi, bus.yi}), 0);

        // busy never rises: degenerate completion 4 cycles after SEND3
        send(6'o12, 6'o34, 6'o56, 1'b0);
        repeat (2) @(negedge clk);
        chk("t2_xy_s3", int'({bus.xi, bus.yi}), 6'o56);
        repeat (3) begin
            @(negedge clk);
            chk("t2_wait", int'(tri_done), 0);
        end
        @(negedge clk);
        chk("t2_done", int'(tri_done), 1);
        chk("t2_pix", int'(pix_cnt), 0);
        @(negedge clk);
        chk("t2_rdy_next", int'(bus.in_ready), 1);
        chk("t2_done_low", int'(tri_done), 0);

        // back-to-back with in_valid held high, one busy cycle
        send(6'o11, 6'o22, 6'o33, 1'b1);
        bus.in_v1 = 6'o44; bus.in_v2 = 6'o55; bus.in_v3 = 6'o66;
        chk("t3_rdy_s1", int'(bus.in_ready), 0);
        repeat (2) @(negedge clk);
        engine(1, 1);
        chk("t3_done", int'(tri_done), 1);
        chk("t3_rdy_done", int'(bus.in_ready), 1);
        chk("t3_pix", int'(pix_cnt), CNT_ON ? 1 : 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("t3_nt_second", int'(bus.nt), 1);
        chk("t3_xy_second", int'({bus.xi, bus.yi}), 6'o44);
        repeat (2) @(negedge clk);
        engine(3, 0);
        chk("t3_done2", int'(tri_done), 1);
        chk("t3_pix2", int'(pix_cnt), 0);
        @(negedge clk);

        // 130 points saturate at 127
        send(6'o70, 6'o07, 6'o25, 1'b0);
        repeat (2) @(negedge clk);
        engine(130, 130);
        chk("t4_done", int'(tri_done), 1);
        chk("t4_pix_sat", int'(pix_cnt), CNT_ON ? 127 : 0);
        @(negedge clk);

        // reset while sending vertex 2
        send(6'o01, 6'o02, 6'o03, 1'b0);
        @(negedge clk);
        chk("t5_xy_s2", int'({bus.xi, bus.yi}), 6'o02);
        #2 reset = 1'b0;
        #1;
        chk("t5_rst_nt", int'(bus.nt), 0);
        chk("t5_rst_xy", int'({bus.xi, bus.yi}), 0);
        chk("t5_rst_rdy", int'(bus.in_ready), 0);
        chk("t5_rst_pix", int'(pix_cnt), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_rdy_release", int'(bus.in_ready), 1);
        repeat (6) begin
            @(negedge clk);
            chk("t5_no_done", int'(tri_done), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tri_vertex_feeder.md
TRI_VERTEX_FEEDER -- requirements
Module: tri_vertex_feeder

Interface
REQ-001 SHALL have parameter BUSY_TIMEOUT, default 4, max cycles after vertex 3 to wait for busy to rise.
REQ-002 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, upstream triangle valid.
REQ-005 SHALL have port in_ready, output, 1, feeder can accept a triangle.
REQ-006 SHALL have ports in_v1, in_v2, in_v3, input, 6 each, vertices packed as x[5:3], y[2:0].
REQ-007 SHALL have port busy, input, 1, engine busy.
REQ-008 SHALL have port po, input, 1, engine point-valid strobe.
REQ-009 SHALL have port nt, output, 1, new-triangle strobe to engine.
REQ-010 SHALL have ports xi, yi, output, 3 each, vertex coordinates to engine.
REQ-011 SHALL have port tri_done, output, 1, one-cycle pulse when engine finishes a triangle.
REQ-012 SHALL have port pix_cnt, output, 7, points emitted for the last completed triangle.

Function
REQ-013 SHALL implement FSM IDLE -> SEND1 -> SEND2 -> SEND3 -> WAIT_HI -> WAIT_LO -> IDLE.
REQ-014 SHALL drive in_ready=1 only in IDLE with busy=0; in_valid&in_ready latches v1..v3 into a holding register; next state SEND1.
REQ-015 SHALL drive nt=1 and {xi,yi}=v1 in SEND1; nt=0 and v2 in SEND2; nt=0 and v3 in SEND3; every output registered.
REQ-016 SHALL drive xi=yi=0 and nt=0 in all states other than SEND1..SEND3.
REQ-017 SHALL move WAIT_HI -> WAIT_LO on busy=1; after BUSY_TIMEOUT cycles with busy=0, SHALL go to IDLE and pulse tri_done with pix_cnt=0 (degenerate triangle).
REQ-018 SHALL move WAIT_LO -> IDLE on the first cycle busy=0, pulsing tri_done and updating pix_cnt in that same cycle.
REQ-019 SHALL increment an internal counter on each po=1 cycle from SEND1 through WAIT_LO, including a po coincident with the busy fall; the counter clears on entry to SEND1.
REQ-020 SHALL saturate the counter at 127.
REQ-021 SHALL hold pix_cnt stable between tri_done pulses.
REQ-022 SHALL ignore busy during SEND1..SEND3 (no abort).
REQ-023 SHALL ignore in_valid outside IDLE; upstream data must remain stable while in_valid=1 and in_ready=0.
REQ-024 SHALL give a minimum triangle-to-triangle spacing of 6 cycles from SEND1 to next SEND1 (busy one cycle).

Reset
REQ-025 SHALL, on reset=0, asynchronously force IDLE, nt=0, xi=yi=0, in_ready=0, tri_done=0, pix_cnt=0, counter=0, holding register=0.
REQ-026 SHALL, on reset mid-triangle, abandon the triangle without a tri_done pulse; in_ready SHALL rise the first cycle after release if busy=0.

Configuration
REQ-027 SHALL count points as in REQ-019 when macro TRI_PIXCNT_EN is defined.
REQ-028 SHALL, when TRI_PIXCNT_EN is undefined, omit the counter, keep the pix_cnt port, and tie pix_cnt to 0; tri_done behaviour is unchanged.

Structure
REQ-029 SHALL take the FSM state enum, the vertex width (6), the coordinate width (3) and the pix_cnt width (7) from shared package tri_pkg.
REQ-030 SHALL implement the saturating point counter as sub-module tri_pix_counter (inputs clr, inc; output 7-bit count).

Verification
REQ-031 SHALL verify: v1=000000, v2=000111, v3=111111; engine holds busy 10 cycles with 8 po -> nt high exactly in SEND1, xi/yi sequence 0/0, 0/7, 7/7, tri_done one cycle, pix_cnt=8.
REQ-032 SHALL verify: busy never rises, BUSY_TIMEOUT=4 -> tri_done 4 cycles after SEND3, pix_cnt=0, in_ready=1 the following cycle.
REQ-033 SHALL verify: two back-to-back triangles with in_valid held high -> second SEND1 no earlier than the cycle after the first tri_done, with no in_ready during busy.
REQ-034 SHALL verify: 130 po pulses in one triangle -> pix_cnt=127.
REQ-035 SHALL verify: reset asserted in SEND2 -> nt=0, xi=yi=0 immediately, no tri_done, in_ready=1 one cycle after release.
REQ-036 SHALL verify: TRI_PIXCNT_EN undefined and the REQ-031 stimulus -> tri_done identical, pix_cnt=0.
